uart_imem_loader: RTL and testbench

Serial boot loader that sits directly upstream of the instruction memory's programming port. It receives a framed program image over a UART RX line and assembles little-endian 32-bit words. It drives the memory's write-enable/address/data inputs one word at a time, and holds the core in reset while a load is in progress. Result status is reported through sticky done/error flags.

---
 rtl/uart_imem_loader_if.sv | 31 +++
 rtl/uart_imem_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_if.sv
// Boot-loader bus: UART input and instruction-memory programming port.
// The loader is the master; the memory/core side is the slave.
interface uart_imem_loader_if;
    logic        uart_rx;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    modport master (
        input  uart_rx,
        output imem_we,
        output imem_addr,
        output imem_wd,
        output cpu_hold,
        output load_done,
        output load_error
    );

    modport slave (
        output uart_rx,
        input  imem_we,
        input  imem_addr,
        input  imem_wd,
        input  cpu_hold,
        input  load_done,
        input  load_error
    );
endinterface

// File: rtl/uart_imem_loader.sv
// UART boot loader: receives A5/N/words/checksum frames and programs the
// instruction memory one word at a time while holding the core in reset.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int MEM_WORDS      = 64,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_imem_loader_if.master    bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERROR} ld_st_e;

    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    rx_st_e        rx_st_q, rx_st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          byte_valid, frame_err;

    ld_st_e        st_q, st_d;
    logic [7:0]    n_q, n_d;
    logic [7:0]    widx_q, widx_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   word_q, word_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wd_q, wd_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tmo_run;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
            rx_st_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            st_q    <= IDLE;
            n_q     <= '0;
            widx_q  <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rx_s1_q <= bus.uart_rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            rx_st_q <= rx_st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            st_q    <= st_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Receiver: rx_s3_q is the previous synchronized sample for edge detect
    always_comb begin
        rx_st_d    = rx_st_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_s3_q && !rx_s2_q)
                    rx_st_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    sh_d  = {rx_s2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        rx_st_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d      = '0;
                    rx_st_d    = RX_IDLE;
                    byte_valid = rx_s2_q;
                    frame_err  = !rx_s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    assign tmo_run = (st_q == COUNT) || (st_q == DATA) || (st_q == CHECK);

    always_comb begin
        st_d   = st_q;
        n_d    = n_q;
        widx_d = widx_q;
        lane_d = lane_q;
        word_d = word_q;
        csum_d = csum_q;
        tmo_d  = tmo_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        wd_d   = wd_q;
        hold_d = hold_q;
        done_d = done_q;
        err_d  = err_q;
        if (tmo_run)
            tmo_d = byte_valid ? '0 : tmo_q + 1'b1;
        unique case (st_q)
            IDLE, DONE, ERROR: begin
                if (byte_valid && sh_q == 8'hA5) begin
                    st_d   = COUNT;
                    hold_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    widx_d = '0;
                    lane_d = '0;
                    csum_d = '0;
                    tmo_d  = '0;
                end
            end
            COUNT: begin
                if (byte_valid) begin
                    if (sh_q == 8'd0 || 32'(sh_q) > 32'(MEM_WORDS)) begin
                        st_d = ERROR;
                    end else begin
                        n_d  = sh_q;
                        st_d = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_valid) begin
                    csum_d = csum_q + sh_q;
                    word_d[{lane_q, 3'b000} +: 8] = sh_q;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we_d   = 1'b1;
                        addr_d = {22'd0, widx_q, 2'b00};
                        wd_d   = {sh_q, word_q[23:0]};
                        widx_d = widx_q + 8'd1;
                        if (widx_q + 8'd1 == n_q)
                            st_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (byte_valid) begin
                    if (sh_q == csum_q) begin
                        st_d   = DONE;
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        st_d = ERROR;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
        if (tmo_run && (frame_err || (!byte_valid && tmo_q == TMAX)))
            st_d = ERROR;
        // A failed load keeps the core parked off the partial image
        if (st_d == ERROR) begin
            err_d  = 1'b1;
            hold_d = 1'b1;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wd    = wd_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_done  = done_q;
    assign bus.load_error = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader at 8 clocks per bit.
// Frames are driven serially; memory writes are captured into queues.
module tb_uart_imem_loader;

    localparam int CPB = 8;
    localparam int TMO = 1000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [7:0]  fr[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    uart_imem_loader_if bus ();

    uart_imem_loader #(
        .CLKS_PER_BIT  (CPB),
        .MEM_WORDS     (64),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.imem_we === 1'b1) begin
            wa.push_back(bus.imem_addr);
            wd.push_back(bus.imem_wd);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.uart_rx = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (CPB) @(negedge CLK);
        end
        bus.uart_rx = stop;
        repeat (CPB) @(negedge CLK);
        bus.uart_rx = 1'b1;
    endtask

    task automatic send_all();
        foreach (fr[i]) send_byte(fr[i], 1'b1);
        repeat (20) @(negedge CLK);
    endtask

    task automatic flags(input string tag, input logic d, input logic e,
                         input logic h);
        check({tag, "_done"}, {31'd0, bus.load_done}, {31'd0, d});
        check({tag, "_err"}, {31'd0, bus.load_error}, {31'd0, e});
        check({tag, "_hold"}, {31'd0, bus.cpu_hold}, {31'd0, h});
    endtask

    task automatic clr();
        wa.delete();
        wd.delete();
    endtask

    task automatic check_nominal(input string tag);
        check({tag, "_nwr"}, wa.size(), 2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, wa[0], 32'h0);
            check({tag, "_d0"}, wd[0], 32'h0010_0013);
            check({tag, "_a1"}, wa[1], 32'h4);
            check({tag, "_d1"}, wd[1], 32'h0000_0093);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"}, {31'd0, bus.imem_we}, 32'd0);
        check({tag, "_addr"}, bus.imem_addr, 32'd0);
        check({tag, "_wd"}, bus.imem_wd, 32'd0);
        flags(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_reset("rst");

        // nominal two-word load
        clr();
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge CLK);
        flags("sync", 1'b0, 1'b0, 1'b1);
        fr = '{8'h02, 8'h13, 8'h00, 8'h10, 8'h00,
               8'h93, 8'h00, 8'h00, 8'h00, 8'hB6};
        send_all();
        check_nominal("nom");
        flags("nom", 1'b1, 1'b0, 1'b0);

        // short glitch while done: no byte, nothing changes
        clr();
        bus.uart_rx = 1'b0;
        repeat (2) @(negedge CLK);
        bus.uart_rx = 1'b1;
        repeat (100) @(negedge CLK);
        check("glitch_nwr", wa.size(), 0);
        flags("glitch", 1'b1, 1'b0, 1'b0);

        // bad checksum
        clr();
        fr = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h10, 8'h00,
               8'h93, 8'h00, 8'h00, 8'h00, 8'hB7};
        send_all();
        check_nominal("bad");
        flags("bad", 1'b0, 1'b1, 1'b1);

        // count zero
        clr();
        fr = '{8'hA5, 8'h00};
        send_all();
        check("n0_nwr", wa.size(), 0);
        flags("n0", 1'b0, 1'b1, 1'b1);

        // count 65
        clr();
        fr = '{8'hA5, 8'h41};
        send_all();
        check("n65_nwr", wa.size(), 0);
        flags("n65", 1'b0, 1'b1, 1'b1);

        // full 64-word image, byte k = k, checksum 0x80
        clr();
        fr = '{8'hA5, 8'h40};
        for (int k = 0; k < 256; k++) fr.push_back(8'(k));
        fr.push_back(8'h80);
        send_all();
        check("n64_nwr", wa.size(), 64);
        if (wa.size() == 64) begin
            for (int w = 0; w < 64; w++) begin
                check("n64_addr", wa[w], 32'(w * 4));
                check("n64_data", wd[w], {8'(4*w+3), 8'(4*w+2),
                                          8'(4*w+1), 8'(4*w)});
            end
            check("n64_last_addr", wa[63], 32'h0000_00FC);
            check("n64_last_data", wd[63], 32'hFFFE_FDFC);
        end
        flags("n64", 1'b1, 1'b0, 1'b0);

        // stop bit low inside DATA
        clr();
        fr = '{8'hA5, 8'h02, 8'h13};
        send_all();
        flags("pre_ferr", 1'b0, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (20) @(negedge CLK);
        check("ferr_nwr", wa.size(), 0);
        flags("ferr", 1'b0, 1'b1, 1'b1);

        // timeout after three data bytes
        clr();
        fr = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h10};
        foreach (fr[i]) send_byte(fr[i], 1'b1);
        repeat (900) @(negedge CLK);
        flags("tmo_early", 1'b0, 1'b0, 1'b1);
        repeat (200) @(negedge CLK);
        check("tmo_nwr", wa.size(), 0);
        flags("tmo", 1'b0, 1'b1, 1'b1);

        // reset after fifth data byte, then recover
        clr();
        fr = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93};
        send_all();
        check("mid_nwr", wa.size(), 1);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check_reset("mid_rst");
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset("post_rst");
        clr();
        fr = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h10, 8'h00,
               8'h93, 8'h00, 8'h00, 8'h00, 8'hB6};
        send_all();
        check_nominal("rec");
        flags("rec", 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
